// File: rtl/adder_sum_accumulator.sv
// Accumulates a programmed block of adder results {co, s} into an overflow-free total
// and counts carry-outs, presenting the total on a valid/ready output handshake.
module adder_sum_accumulator #(
  parameter  int DATA_W = 32,
  parameter  int CNT_W  = 8,
  localparam int ACC_W  = DATA_W + 1 + CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] s,
  input  logic              co,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  co_count,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] remaining;
  logic             accept;

  // Handshake outputs decode only from the registered state.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (accept && remaining == CNT_W'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out   <= '0;
      co_count  <= '0;
      remaining <= '0;
    end else begin
      if (state == IDLE && start) begin
        remaining <= len;
        acc_out   <= '0;
        co_count  <= '0;
      end else if (accept) begin
        acc_out   <= acc_out + ACC_W'({co, s});
        co_count  <= co_count + CNT_W'(co);
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench for adder_sum_accumulator: expected totals go into a scoreboard
// queue as blocks are driven and are popped when the DUT presents out_valid.
module tb_adder_sum_accumulator;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;
  localparam int ACC_W  = DATA_W + 1 + CNT_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] s;
  logic              co;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  co_count;
  logic              busy;

  adder_sum_accumulator #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .s(s), .co(co),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc_out(acc_out), .co_count(co_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  logic [ACC_W-1:0] model_acc;
  logic [CNT_W-1:0] model_cnt;
  int               checks = 0;
  int               errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after the start edge.
  task automatic start_block(input logic [CNT_W-1:0] l);
    start     = 1'b1;
    len       = l;
    model_acc = '0;
    model_cnt = '0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_result(input int gap, input logic c, input logic [DATA_W-1:0] d);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    check("in_ready_before_send", in_ready, 1'b1);
    in_valid  = 1'b1;
    co        = c;
    s         = d;
    model_acc = model_acc + ACC_W'({c, d});
    model_cnt = model_cnt + CNT_W'(c);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_expected();
    exp_t e;
    e.acc = model_acc;
    e.cnt = model_cnt;
    sb.push_back(e);
  endtask

  task automatic wait_output(input string tag);
    exp_t e;
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    check({tag, "_out_valid"}, out_valid, 1'b1);
    check({tag, "_sb_nonempty"}, (sb.size() > 0), 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_acc_out"}, acc_out, e.acc);
      check({tag, "_co_count"}, co_count, e.cnt);
    end
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_idle_out_valid"}, out_valid, 1'b0);
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    s = '0; co = 1'b0; out_ready = 1'b0;
    model_acc = '0; model_cnt = '0;
    repeat (2) @(negedge clk);
    check("rst_acc_out", acc_out, '0);
    check("rst_co_count", co_count, '0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1'b0);

    // len=3 back-to-back
    start_block(8'd3);
    check("len3_busy", busy, 1'b1);
    send_result(0, 1'b0, 32'd1);
    send_result(0, 1'b0, 32'd2);
    send_result(0, 1'b0, 32'd3);
    push_expected();
    check("len3_out_valid_next", out_valid, 1'b1);
    check("len3_in_ready_low", in_ready, 1'b0);
    wait_output("len3");
    check("len3_const_acc", acc_out, 64'd6);
    drain("len3");

    // len=2 with carries and a 3-cycle gap
    start_block(8'd2);
    send_result(0, 1'b1, 32'hFFFF_FFFF);
    send_result(3, 1'b1, 32'hFFFF_FFFF);
    push_expected();
    wait_output("len2gap");
    check("len2gap_const_acc", acc_out, 64'h3_FFFF_FFFE);
    drain("len2gap");

    // len=0 goes straight to DONE
    start_block(8'd0);
    push_expected();
    check("len0_in_ready", in_ready, 1'b0);
    check("len0_out_valid", out_valid, 1'b1);
    wait_output("len0");
    drain("len0");

    // DONE hold with in_valid and start asserted
    start_block(8'd1);
    send_result(0, 1'b1, 32'h7);
    push_expected();
    wait_output("hold");
    in_valid = 1'b1; start = 1'b1; s = 32'h55; co = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_acc_out", acc_out, model_acc);
      check("hold_co_count", co_count, model_cnt);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b0;
    check("hold_exit_out_valid", out_valid, 1'b0);
    check("hold_exit_busy", busy, 1'b0);
    @(negedge clk);
    check("hold_no_restart_busy", busy, 1'b0);
    check("idle_hold_acc_out", acc_out, model_acc);
    check("idle_hold_co_count", co_count, model_cnt);

    // async reset mid-block after 2 of 5 results
    start_block(8'd5);
    send_result(0, 1'b0, 32'h1);
    send_result(0, 1'b1, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_acc_out", acc_out, '0);
    check("midrst_co_count", co_count, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_block(8'd1);
    send_result(0, 1'b0, 32'h5);
    push_expected();
    wait_output("postrst");
    check("postrst_const_acc", acc_out, 64'h5);
    drain("postrst");

    // maximum block length, all-ones with carry
    start_block(8'd255);
    for (int i = 0; i < 255; i++) send_result(0, 1'b1, 32'hFFFF_FFFF);
    push_expected();
    wait_output("len255");
    check("len255_const_acc", acc_out, 64'h1FD_FFFF_FF01);
    check("len255_const_cnt", co_count, 64'd255);
    drain("len255");

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_sum_accumulator.md
Name: adder_sum_accumulator

Overview:
- Downstream stage of the 32-bit adder family (structure/dataflow/behavior, plain or registered).
- Consumes a stream of adder results {co, s} over a valid/ready handshake.
- Accumulates a programmed number of results into a wide, overflow-free total and counts carry-outs.
- Presents the total on an output valid/ready handshake for the result checker or bus.

Parameters:
- DATA_W, 32, width of adder sum s.
- CNT_W, 8, width of block length and carry counter; maximum block length 2^CNT_W-1.
- ACC_W, DATA_W+1+CNT_W (41), accumulator width. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a block; sampled only in IDLE
- len  input  CNT_W  number of results in the block; latched on accepted start
- in_valid  input  1  upstream result valid
- in_ready  output  1  high when a result can be accepted
- s  input  DATA_W  adder sum
- co  input  1  adder carry-out
- out_valid  output  1  block total available
- out_ready  input  1  downstream accepts total
- acc_out  output  ACC_W  accumulated total
- co_count  output  CNT_W  number of accepted results with co=1
- busy  output  1  high in ACCUM or DONE

Behaviour:
- Async reset (rst_n=0) forces these values immediately, regardless of clk:
  - state=IDLE
  - acc_out=0, co_count=0, remaining=0
  - out_valid=0, in_ready=0, busy=0
- Reset mid-block discards the partial total; no output is produced for that block.
- State machine has three states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1: latch len into remaining; clear acc_out and co_count.
  - If len==0, go to DONE; otherwise go to ACCUM.
- ACCUM:
  - in_ready=1 (decoded from the registered state).
  - An accept is in_valid&&in_ready on a rising edge.
  - On accept: acc_out <= acc_out + zero-extended {co,s} (33-bit value); co_count <= co_count + co; remaining <= remaining-1.
  - On an accept with remaining==1, go to DONE.
  - Gaps in in_valid are allowed with no time limit; state and values hold.
- DONE:
  - out_valid=1 and in_ready=0; acc_out and co_count are held stable.
  - in_valid is ignored and no data is consumed.
  - On out_valid&&out_ready, go to IDLE; out_valid deasserts the following cycle.
- Latency:
  - out_valid rises on the clock edge that accepts the final result, so it is visible in the next cycle.
  - For len==0, out_valid is visible the cycle after start.
- Output hold: acc_out and co_count keep the last block's values in IDLE until the next accepted start.
- Ignored or simultaneous events:
  - start in ACCUM or DONE is ignored.
  - start together with out_ready in DONE is ignored; start must be reasserted in IDLE.
- Width rule: the maximum total is (2^CNT_W-1)*(2^(DATA_W+1)-1), which is less than 2^ACC_W.
  - No overflow is possible and no wrap is required.
  - co_count cannot exceed len, so it cannot wrap.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.

Test Plan:
- rst_n=0 asserted during ACCUM after 2 of 5 results -> outputs become 0 immediately and state is IDLE; a following start with len=1 and one result {0,0x5} -> acc_out=0x5.
- start with len=3, back-to-back results {0,1},{0,2},{0,3} -> in_ready high for those 3 cycles; out_valid in the next cycle; acc_out=6, co_count=0.
- start with len=2, results {1,0xFFFFFFFF} twice with an idle gap of 3 cycles between them -> acc_out=0x3FFFFFFFE, co_count=2.
- start with len=0 -> in_ready never asserts; out_valid the cycle after start; acc_out=0, co_count=0.
- In DONE, hold out_ready=0 for 5 cycles with in_valid=1 and start=1 -> acc_out and co_count stable, nothing consumed, no restart; out_ready=1 -> IDLE next cycle.
- start with len=255, all results {1,0xFFFFFFFF} -> acc_out=0x1FDFFFFFF01, co_count=255, no wrap.
